// File: rtl/kf6845_pkg.sv
// Shared types and widths for the KF6845 CRTC vertical address generator.
package kf6845_pkg;

   localparam int MA_WIDTH = 14;
   localparam int RA_WIDTH = 5;

   typedef enum logic {
      ROWS   = 1'b0,
      ADJUST = 1'b1
   } address_state_t;

endpackage

// File: rtl/kf6845_row_counter.sv
// Scan-line (RA) and vertical-adjust line counter with end-of-row and end-of-adjust flags.
module kf6845_row_counter
   import kf6845_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic                line_end,
   input  logic                in_adjust,
   input  logic                reload,
   input  logic [RA_WIDTH-1:0] reload_value,
   input  logic                step_two,
   input  logic                odd_field,
   input  logic [4:0]          max_scan_line,
   input  logic [4:0]          vertical_total_adjust,
   output logic [RA_WIDTH-1:0] ra,
   output logic                row_end,
   output logic                adjust_end
);

   logic [RA_WIDTH-1:0] adj;
   logic [RA_WIDTH:0]   ra_plus_one;
   logic [RA_WIDTH:0]   end_threshold;

   // Interlaced end test ra >= r9-1+odd is rewritten as ra+1 >= r9+odd to avoid underflow at r9=0.
   always_comb begin
      ra_plus_one   = {1'b0, ra} + (RA_WIDTH + 1)'(1);
      end_threshold = {1'b0, max_scan_line} + {{RA_WIDTH{1'b0}}, odd_field};
      row_end       = step_two ? (ra_plus_one >= end_threshold) : (ra == max_scan_line);
      adjust_end    = (adj == vertical_total_adjust - 5'd1);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ra  <= '0;
         adj <= '0;
      end else if (line_end) begin
         if (reload) begin
            ra  <= reload_value;
            adj <= '0;
         end else begin
            ra <= ra + (step_two ? RA_WIDTH'(2) : RA_WIDTH'(1));
            if (in_adjust) adj <= adj + RA_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/kf6845_address_generator.sv
// KF6845 vertical/linear address generator: MA, RA, V_total and V_display.
// Optional interlace (R8, ODD_FIELD) is enabled by defining KF6845_INTERLACE_VIDEO_EN.
module kf6845_address_generator
   import kf6845_pkg::*;
#(
   parameter int                  ROW_WIDTH           = 7,
   parameter logic [MA_WIDTH-1:0] START_ADDRESS_RESET = 14'h0000
)(
   input  logic                clock,
   input  logic                reset,
   input  logic                video_clock_enable,
   input  logic [7:0]          internal_data_bus_in,
   input  logic                write_horizontal_displayed_register,
   input  logic                write_vertical_total_register,
   input  logic                write_vertical_total_adjust_register,
   input  logic                write_vertical_displayed_register,
   input  logic                write_maximum_scan_line_register,
   input  logic                write_start_address_h_register,
   input  logic                write_start_address_l_register,
   input  logic                H_end,
`ifdef KF6845_INTERLACE_VIDEO_EN
   input  logic                write_interlace_mode_register,
   output logic                ODD_FIELD,
`endif
   output logic [MA_WIDTH-1:0] MA,
   output logic [RA_WIDTH-1:0] RA,
   output logic                V_total,
   output logic                V_display
);

   logic [7:0]           r1;
   logic [ROW_WIDTH-1:0] r4, r6;
   logic [4:0]           r5, r9;
   logic [MA_WIDTH-1:0]  start_address;

   address_state_t       state, next_state;
   logic [ROW_WIDTH-1:0] row, next_row;
   logic [MA_WIDTH-1:0]  row_start, next_row_start;
   logic                 line_end, row_end, adjust_end;
   logic                 frame_end, advance_row_start, row_inc;
   logic                 step_two, odd_field;
   logic [RA_WIDTH-1:0]  reload_value;

   assign line_end       = video_clock_enable & H_end;
   assign next_row_start = row_start + MA_WIDTH'(r1);

   // Register writes land immediately, independent of the character clock qualifier.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r1            <= '0;
         r4            <= '0;
         r5            <= '0;
         r6            <= '0;
         r9            <= '0;
         start_address <= START_ADDRESS_RESET;
      end else begin
         if (write_horizontal_displayed_register)  r1 <= internal_data_bus_in;
         if (write_vertical_total_register)        r4 <= ROW_WIDTH'(internal_data_bus_in[6:0]);
         if (write_vertical_total_adjust_register) r5 <= internal_data_bus_in[4:0];
         if (write_vertical_displayed_register)    r6 <= ROW_WIDTH'(internal_data_bus_in[6:0]);
         if (write_maximum_scan_line_register)     r9 <= internal_data_bus_in[4:0];
         if (write_start_address_h_register)       start_address[13:8] <= internal_data_bus_in[5:0];
         if (write_start_address_l_register)       start_address[7:0]  <= internal_data_bus_in;
      end
   end

`ifdef KF6845_INTERLACE_VIDEO_EN
   logic [1:0] r8;

   assign step_two     = (r8 == 2'b11);
   assign ODD_FIELD    = odd_field;
   assign reload_value = (frame_end && step_two) ? {4'b0, ~odd_field} : {4'b0, odd_field};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r8        <= '0;
         odd_field <= 1'b0;
      end else begin
         if (write_interlace_mode_register) r8 <= internal_data_bus_in[1:0];
         if (!step_two)      odd_field <= 1'b0;
         else if (frame_end) odd_field <= ~odd_field;
      end
   end
`else
   assign step_two     = 1'b0;
   assign odd_field    = 1'b0;
   assign reload_value = '0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= ROWS;
      else        state <= next_state;
   end

   // Line-end decisions: next scan line, next character row, vertical adjust, or frame end.
   always_comb begin
      next_state        = state;
      frame_end         = 1'b0;
      advance_row_start = 1'b0;
      row_inc           = 1'b0;
      if (line_end) begin
         case (state)
            ROWS: begin
               if (row_end) begin
                  if (row != r4) begin
                     row_inc           = 1'b1;
                     advance_row_start = 1'b1;
                  end else if (r5 != 5'd0) begin
                     next_state        = ADJUST;
                     advance_row_start = 1'b1;
                  end else begin
                     frame_end = 1'b1;
                  end
               end
            end
            ADJUST: begin
               if (adjust_end) frame_end = 1'b1;
            end
            default: frame_end = 1'b0;
         endcase
         if (frame_end) next_state = ROWS;
      end
      next_row = frame_end ? '0 : (row_inc ? row + ROW_WIDTH'(1) : row);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         row       <= '0;
         row_start <= START_ADDRESS_RESET;
         MA        <= START_ADDRESS_RESET;
         V_total   <= 1'b0;
         V_display <= 1'b0;
      end else begin
         V_total <= frame_end;
         if (video_clock_enable) begin
            if (!H_end) begin
               MA <= MA + MA_WIDTH'(1);
            end else if (frame_end) begin
               MA        <= start_address;
               row_start <= start_address;
            end else if (advance_row_start) begin
               MA        <= next_row_start;
               row_start <= next_row_start;
            end else begin
               MA <= row_start;
            end
         end
         if (line_end) begin
            row       <= next_row;
            V_display <= (next_state == ROWS) && (next_row < r6);
         end
      end
   end

   kf6845_row_counter u_row_counter (
      .clock                 (clock),
      .reset                 (reset),
      .line_end              (line_end),
      .in_adjust             (state == ADJUST),
      .reload                (advance_row_start | frame_end),
      .reload_value          (reload_value),
      .step_two              (step_two),
      .odd_field             (odd_field),
      .max_scan_line         (r9),
      .vertical_total_adjust (r5),
      .ra                    (RA),
      .row_end               (row_end),
      .adjust_end            (adjust_end)
   );

endmodule

// File: tb/tb_kf6845_address_generator.sv
// Directed self-checking bench for kf6845_address_generator (interlace part needs KF6845_INTERLACE_VIDEO_EN).
module tb_kf6845_address_generator;

   logic        clock;
   logic        reset;
   logic        video_clock_enable;
   logic [7:0]  internal_data_bus_in;
   logic        write_horizontal_displayed_register;
   logic        write_vertical_total_register;
   logic        write_vertical_total_adjust_register;
   logic        write_vertical_displayed_register;
   logic        write_maximum_scan_line_register;
   logic        write_start_address_h_register;
   logic        write_start_address_l_register;
   logic        H_end;
   logic [13:0] MA;
   logic [4:0]  RA;
   logic        V_total;
   logic        V_display;
`ifdef KF6845_INTERLACE_VIDEO_EN
   logic        write_interlace_mode_register;
   logic        ODD_FIELD;
`endif

   int errors = 0;
   int checks = 0;
   int pulses;

   kf6845_address_generator dut (
      .clock                                (clock),
      .reset                                (reset),
      .video_clock_enable                   (video_clock_enable),
      .internal_data_bus_in                 (internal_data_bus_in),
      .write_horizontal_displayed_register  (write_horizontal_displayed_register),
      .write_vertical_total_register        (write_vertical_total_register),
      .write_vertical_total_adjust_register (write_vertical_total_adjust_register),
      .write_vertical_displayed_register    (write_vertical_displayed_register),
      .write_maximum_scan_line_register     (write_maximum_scan_line_register),
      .write_start_address_h_register       (write_start_address_h_register),
      .write_start_address_l_register       (write_start_address_l_register),
      .H_end                                (H_end),
`ifdef KF6845_INTERLACE_VIDEO_EN
      .write_interlace_mode_register        (write_interlace_mode_register),
      .ODD_FIELD                            (ODD_FIELD),
`endif
      .MA                                   (MA),
      .RA                                   (RA),
      .V_total                              (V_total),
      .V_display                            (V_display)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish within time limit");
      $fatal(1, "[TB] timeout");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic char_clock(input logic h);
      video_clock_enable = 1'b1;
      H_end              = h;
      tick();
   endtask

   task automatic run_line();
      repeat (4) char_clock(1'b0);
      char_clock(1'b1);
   endtask

   task automatic write_register(input int index, input logic [7:0] value);
      video_clock_enable   = 1'b0;
      H_end                = 1'b0;
      internal_data_bus_in = value;
      case (index)
         1:  write_horizontal_displayed_register  = 1'b1;
         4:  write_vertical_total_register        = 1'b1;
         5:  write_vertical_total_adjust_register = 1'b1;
         6:  write_vertical_displayed_register    = 1'b1;
         9:  write_maximum_scan_line_register     = 1'b1;
         12: write_start_address_h_register       = 1'b1;
         13: write_start_address_l_register       = 1'b1;
`ifdef KF6845_INTERLACE_VIDEO_EN
         8:  write_interlace_mode_register        = 1'b1;
`endif
         default: ;
      endcase
      tick();
      write_horizontal_displayed_register  = 1'b0;
      write_vertical_total_register        = 1'b0;
      write_vertical_total_adjust_register = 1'b0;
      write_vertical_displayed_register    = 1'b0;
      write_maximum_scan_line_register     = 1'b0;
      write_start_address_h_register       = 1'b0;
      write_start_address_l_register       = 1'b0;
`ifdef KF6845_INTERLACE_VIDEO_EN
      write_interlace_mode_register        = 1'b0;
`endif
   endtask

   // Expected per-line values for one programmed frame: row-start MA, RA, and V_display/V_total after H_end.
   logic [15:0] frame_ma [7] = '{16'h10, 16'h10, 16'h14, 16'h14, 16'h18, 16'h18, 16'h1C};
   logic [15:0] frame_ra [7] = '{16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'd1, 16'd0};
   logic [15:0] frame_vd [7] = '{16'd1, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd1};
   logic [15:0] frame_vt [7] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1};

   initial begin
      reset                                = 1'b0;
      video_clock_enable                   = 1'b0;
      H_end                                = 1'b0;
      internal_data_bus_in                 = 8'h00;
      write_horizontal_displayed_register  = 1'b0;
      write_vertical_total_register        = 1'b0;
      write_vertical_total_adjust_register = 1'b0;
      write_vertical_displayed_register    = 1'b0;
      write_maximum_scan_line_register     = 1'b0;
      write_start_address_h_register       = 1'b0;
      write_start_address_l_register       = 1'b0;
`ifdef KF6845_INTERLACE_VIDEO_EN
      write_interlace_mode_register        = 1'b0;
`endif

      repeat (3) tick();
      check_output("reset_ma", 16'(MA), 16'h0000);
      check_output("reset_ra", 16'(RA), 16'h0000);
      check_output("reset_vtotal", 16'(V_total), 16'h0000);
      check_output("reset_vdisplay", 16'(V_display), 16'h0000);
      reset = 1'b1;
      tick();
      char_clock(1'b0);
      check_output("first_increment", 16'(MA), 16'h0001);

      write_register(1, 8'd4);
      write_register(9, 8'd1);
      write_register(4, 8'd2);
      write_register(5, 8'd1);
      write_register(6, 8'd2);
      write_register(12, 8'h00);
      write_register(13, 8'h10);

      // Run out the frame already in progress so the new start address is loaded.
      repeat (7) run_line();
      check_output("first_frame_vtotal", 16'(V_total), 16'h0001);
      check_output("first_frame_reload", 16'(MA), 16'h0010);

      for (int i = 0; i < 7; i++) begin
         check_output($sformatf("line%0d_ma_start", i), 16'(MA), frame_ma[i]);
         check_output($sformatf("line%0d_ra", i), 16'(RA), frame_ra[i]);
         repeat (4) char_clock(1'b0);
         check_output($sformatf("line%0d_ma_last", i), 16'(MA), frame_ma[i] + 16'd4);
         char_clock(1'b1);
         check_output($sformatf("line%0d_vdisplay", i), 16'(V_display), frame_vd[i]);
         check_output($sformatf("line%0d_vtotal", i), 16'(V_total), frame_vt[i]);
      end
      video_clock_enable = 1'b0;
      H_end              = 1'b0;
      tick();
      check_output("vtotal_one_clock", 16'(V_total), 16'h0000);
      check_output("frame_reload_ma", 16'(MA), 16'h0010);

      write_register(5, 8'd0);
      pulses = 0;
      for (int i = 1; i <= 12; i++) begin
         run_line();
         if (V_total === 1'b1) pulses++;
         if (i == 6) check_output("r5zero_reload", 16'(MA), 16'h0010);
      end
      check_output("r5zero_pulses", 16'(pulses), 16'd2);

      repeat (2) char_clock(1'b0);
      video_clock_enable = 1'b0;
      H_end              = 1'b1;
      repeat (10) tick();
      check_output("gated_ma", 16'(MA), 16'h0012);
      check_output("gated_ra", 16'(RA), 16'h0000);
      write_register(12, 8'h3F);
      write_register(13, 8'hFE);
      repeat (2) char_clock(1'b0);
      char_clock(1'b1);
      check_output("midframe_ra", 16'(RA), 16'h0001);
      check_output("midframe_ma", 16'(MA), 16'h0010);
      run_line();
      check_output("gated_row", 16'(MA), 16'h0014);
      repeat (4) run_line();
      check_output("new_start_vtotal", 16'(V_total), 16'h0001);
      check_output("new_start_ma", 16'(MA), 16'h3FFE);
      char_clock(1'b0);
      check_output("ma_top", 16'(MA), 16'h3FFF);
      char_clock(1'b0);
      check_output("ma_wrap", 16'(MA), 16'h0000);

      repeat (2) char_clock(1'b0);
      char_clock(1'b1);
      run_line();
      check_output("row_start_wrap", 16'(MA), 16'h0002);
      check_output("row1_vdisplay", 16'(V_display), 16'h0001);
      repeat (2) char_clock(1'b0);
      #2;
      reset = 1'b0;
      #1;
      check_output("async_reset_ma", 16'(MA), 16'h0000);
      check_output("async_reset_ra", 16'(RA), 16'h0000);
      check_output("async_reset_vdisplay", 16'(V_display), 16'h0000);
      video_clock_enable = 1'b1;
      H_end              = 1'b1;
      repeat (2) tick();
      check_output("reset_no_vtotal", 16'(V_total), 16'h0000);
      reset = 1'b1;

      char_clock(1'b1);
      check_output("one_line_vtotal_a", 16'(V_total), 16'h0001);
      char_clock(1'b1);
      check_output("one_line_vtotal_b", 16'(V_total), 16'h0001);
      check_output("one_line_ma", 16'(MA), 16'h0000);

      write_register(9, 8'd3);
      char_clock(1'b1);
      char_clock(1'b1);
      check_output("ra_before_rewrite", 16'(RA), 16'h0002);
      write_register(9, 8'd1);
      pulses = 0;
      repeat (31) begin
         char_clock(1'b1);
         if (V_total === 1'b1) pulses++;
      end
      check_output("ra_wrap_value", 16'(RA), 16'h0001);
      check_output("ra_wrap_no_pulse", 16'(pulses), 16'd0);
      char_clock(1'b1);
      check_output("ra_wrap_frame_end", 16'(V_total), 16'h0001);

`ifdef KF6845_INTERLACE_VIDEO_EN
      reset = 1'b0;
      tick();
      reset = 1'b1;
      write_register(8, 8'd3);
      write_register(9, 8'd3);
      char_clock(1'b1);
      check_output("even_ra_step", 16'(RA), 16'h0002);
      check_output("even_odd_field", 16'(ODD_FIELD), 16'h0000);
      char_clock(1'b1);
      check_output("even_end_vtotal", 16'(V_total), 16'h0001);
      check_output("odd_field_set", 16'(ODD_FIELD), 16'h0001);
      check_output("odd_ra_start", 16'(RA), 16'h0001);
      char_clock(1'b1);
      check_output("odd_ra_step", 16'(RA), 16'h0003);
      char_clock(1'b1);
      check_output("odd_end_vtotal", 16'(V_total), 16'h0001);
      check_output("odd_field_clear", 16'(ODD_FIELD), 16'h0000);
      check_output("even_ra_start", 16'(RA), 16'h0000);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/kf6845_address_generator.md
Name: kf6845_address_generator

Overview:
Vertical/linear address generator for the KF6845 CRTC. It produces the refresh memory address MA, row address RA and the one-clock V_total frame pulse that the cursor, display-enable and blink logic consume. It is driven by the horizontal timing block's line-end strobe and is programmed over the internal data bus with registers R1, R4, R5, R6, R9, R12 and R13.

Parameters:
ROW_WIDTH, 7, width of the character-row counter and of R4/R6.
START_ADDRESS_RESET, 14'h0000, value R12/R13 take in reset.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
video_clock_enable  in  1  character-clock qualifier; all counting is gated by it
internal_data_bus_in  in  8  register write data
write_horizontal_displayed_register  in  1  R1 write strobe, data[7:0]
write_vertical_total_register  in  1  R4 write strobe, data[6:0]
write_vertical_total_adjust_register  in  1  R5 write strobe, data[4:0]
write_vertical_displayed_register  in  1  R6 write strobe, data[6:0]
write_maximum_scan_line_register  in  1  R9 write strobe, data[4:0]
write_start_address_h_register  in  1  R12 write strobe, data[5:0]
write_start_address_l_register  in  1  R13 write strobe, data[7:0]
H_end  in  1  last character of a scan line; single character-clock pulse
MA  out  14  refresh memory address
RA  out  5  row (scan-line) address
V_total  out  1  frame-end pulse, exactly one clock wide
V_display  out  1  high while the row counter is below R6 and state is ROWS

Behaviour:
- Reset (reset low, async): all registers 0 except start address = START_ADDRESS_RESET; MA = START_ADDRESS_RESET; RA=0; row=0; row_start=START_ADDRESS_RESET; state ROWS; V_total=0; V_display=0.
- Register writes:
  - Take effect on the clock edge they are sampled; they are not gated by video_clock_enable.
  - R12/R13 update independent halves of a 14-bit value.
  - The start address is used only at the next frame reload.
- Counting happens only on clocks with video_clock_enable=1.
- When H_end=0: MA <= MA+1, mod 2^14.
- When H_end=1 in state ROWS:
  - RA != R9: RA+1; MA <= row_start.
  - RA == R9 and row != R4: RA 0; row+1; row_start += R1 (mod 2^14); MA <= new row_start.
  - RA == R9, row == R4, R5 != 0: go to ADJUST; RA 0; adj=0; row_start += R1; MA <= new row_start.
  - RA == R9, row == R4, R5 == 0: frame end.
- When H_end=1 in state ADJUST:
  - adj == R5-1: frame end.
  - Otherwise: adj+1; RA+1; MA <= row_start.
- Frame end: row 0, RA 0, state ROWS, row_start and MA <= start address, V_total <= 1.
- V_total clears on the next clock edge, enabled or not, so it is exactly one clock wide.
- V_display is registered: (state==ROWS) && (row < R6), updated together with row.
- RA compare uses equality; if RA > R9 after R9 is rewritten, RA counts up and wraps mod 32 to reach equality.
- Row counter compare also uses equality; it wraps mod 2^ROW_WIDTH.
- R4=0 and R9=0 give one-line frames; V_total then pulses on every H_end.
- Reset mid-frame aborts immediately to the reset state with no V_total pulse.

Optional Feature:
- Macro KF6845_INTERLACE_VIDEO_EN.
- When defined:
  - Adds port write_interlace_mode_register (R8, data[1:0]) and output ODD_FIELD.
  - With R8==2'b11, RA steps by 2 and starts at ODD_FIELD (0 or 1); the end test becomes RA >= R9-1+ODD_FIELD.
  - ODD_FIELD toggles at each frame end.
  - Other R8 values give normal behaviour with ODD_FIELD held 0.
- When not defined: ports absent; RA always steps by 1.

Decomposition:
- Package kf6845_pkg: enum address_state_t {ROWS, ADJUST}; constants MA_WIDTH=14, RA_WIDTH=5.
- One natural sub-module, kf6845_row_counter: the RA/adjust scan-line counter with its end-of-row flag. The top keeps row, row_start, MA and the register bank.

Test Plan:
- Reset: hold reset low, then release -> MA=0, RA=0, V_total=0, V_display=0; the first enabled clock without H_end gives MA=1.
- Full frame trace:
  - Program R1=4, R9=1, R4=2, R5=1, R6=2, start=0x0010; 5 characters per line (H_end on the 5th) -> rows 0/1/2 start at MA 0x10/0x14/0x18.
  - RA sequence per row is 0,1; V_display is 1 for rows 0-1 and 0 for row 2 and the adjust line.
  - One adjust line starts at MA 0x1C; then V_total is high for exactly one clock and MA reloads to 0x10.
- R5=0 with the same setup: the frame ends directly after row 2 RA1 with no ADJUST state; V_total pulses count one per 6 lines.
- Enable gating and start address: video_clock_enable low for 10 clocks with H_end high -> no change to MA, RA or row. Write start=0x3FFE mid-frame -> the current frame is unaffected; the next frame starts at 0x3FFE, and MA wraps 0x3FFF -> 0x0000.
- Reset mid-frame: assert reset during row 1 -> outputs at reset values immediately; no V_total pulse.
- With KF6845_INTERLACE_VIDEO_EN and R8=3, R9=3 -> even field RA 0,2; odd field RA 1,3; ODD_FIELD toggles on each V_total.
